// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side UART transmitter.
package fifo_pkg;

    // Transmitter sequencing states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    // UART line levels.
    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last count.
module baud_tick_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk_r,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running count within a bit period, held at zero while cleared.
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Tick on the final cycle of each bit period.
    always_comb begin
        bit_tick = (cnt == LAST) && !clr;
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the read side of the FIFO and serialises them as UART frames.
module fifo_uart_tx
    import fifo_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk_r,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_out,
    output logic              rd_en,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       tx_count
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic              parity_bit;
    logic              parity_next;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_cnt_next;

    logic bit_tick;
    logic baud_clr;
    logic fetch_ok;
    logic last_data;
    logic last_stop;

    logic tx_next;
    logic rd_en_next;
    logic busy_next;

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_r   (clk_r),
        .rst     (rst),
        .clr     (baud_clr),
        .bit_tick(bit_tick)
    );

    // Frame-position qualifiers shared by the FSM and the datapath.
    always_comb begin
        baud_clr  = !((state == START) || (state == DATA) ||
                      (state == PARITY) || (state == STOP));
        fetch_ok  = tx_en && !buf_empty;
        last_data = (state == DATA) && bit_tick && (bit_cnt == LAST_DATA);
        last_stop = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);
    end

    // State register.
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decision; buf_empty is only consulted in IDLE and on the last stop cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (fetch_ok) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = START;
            START:   if (bit_tick) next_state = DATA;
            DATA:    if (last_data) next_state = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY:  if (bit_tick) next_state = STOP;
            STOP:    if (last_stop) next_state = fetch_ok ? FETCH : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values for shift register, parity and bit counter.
    always_comb begin
        shreg_next   = shreg;
        parity_next  = parity_bit;
        bit_cnt_next = bit_cnt;
        if (state == LOAD) begin
            shreg_next  = buf_out;
            parity_next = ^buf_out;
        end
        if ((state == DATA) && bit_tick) begin
            shreg_next = shreg >> 1;
        end
        if (next_state != state) begin
            bit_cnt_next = '0;
        end else if (bit_tick && ((state == DATA) || (state == STOP))) begin
            bit_cnt_next = bit_cnt + BIT_W'(1);
        end
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        rd_en_next = (next_state == FETCH);
        busy_next  = (next_state != IDLE);
        frame_done = last_stop;
        unique case (next_state)
            START:   tx_next = UART_START;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = UART_IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            tx         <= UART_IDLE;
            rd_en      <= 1'b0;
            busy       <= 1'b0;
            tx_count   <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            tx         <= tx_next;
            rd_en      <= rd_en_next;
            busy       <= busy_next;
            shreg      <= shreg_next;
            parity_bit <= parity_next;
            bit_cnt    <= bit_cnt_next;
            if (last_stop) begin
                tx_count <= tx_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a queue-style FIFO model and a
// frame-level waveform model of the UART line.
module tb_fifo_uart_tx;

    localparam int CPB  = 4;
    localparam int MAXC = 512;

    logic clk_r = 1'b0;
    always #5 clk_r = ~clk_r;

    logic       rst;
    logic       tx_en0, tx_en1;
    logic       buf_empty;
    logic [7:0] buf_out;

    logic        rd_en0, tx0, busy0, fd0;
    logic [15:0] cnt0;
    logic        rd_en1, tx1, busy1, fd1;
    logic [15:0] cnt1;

    int tests  = 0;
    int failed = 0;

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8),
        .PARITY_EN   (0),
        .STOP_BITS   (1)
    ) dut (
        .clk_r     (clk_r),
        .rst       (rst),
        .tx_en     (tx_en0),
        .buf_empty (buf_empty),
        .buf_out   (buf_out),
        .rd_en     (rd_en0),
        .tx        (tx0),
        .busy      (busy0),
        .frame_done(fd0),
        .tx_count  (cnt0)
    );

    fifo_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_W      (8),
        .PARITY_EN   (1),
        .STOP_BITS   (2)
    ) dut_p (
        .clk_r     (clk_r),
        .rst       (rst),
        .tx_en     (tx_en1),
        .buf_empty (buf_empty),
        .buf_out   (buf_out),
        .rd_en     (rd_en1),
        .tx        (tx1),
        .busy      (busy1),
        .frame_done(fd1),
        .tx_count  (cnt1)
    );

    // FIFO model shared by both instances; only one is ever enabled at a time.
    logic [7:0]  mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    int          underflow = 0;

    assign buf_empty = (wr_ptr == rd_ptr);

    always @(posedge clk_r) begin
        if (rd_en0 || rd_en1) begin
            if (wr_ptr == rd_ptr) begin
                underflow <= underflow + 1;
            end else begin
                buf_out <= mem[rd_ptr[7:0]];
                rd_ptr  <= rd_ptr + 1;
            end
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    // Capture buffers and expected waveforms.
    logic c_tx [0:MAXC-1];
    logic c_rd [0:MAXC-1];
    logic c_fd [0:MAXC-1];
    logic c_bz [0:MAXC-1];
    logic e_tx [0:MAXC-1];
    logic e_rd [0:MAXC-1];
    logic e_fd [0:MAXC-1];
    logic e_bz [0:MAXC-1];
    logic [7:0] mbytes [0:15];
    int cap_sel = 0;
    int exp_cnt0 = 0;
    int exp_cnt1 = 0;

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_r);
            c_tx[k] = (cap_sel == 1) ? tx1    : tx0;
            c_rd[k] = (cap_sel == 1) ? rd_en1 : rd_en0;
            c_fd[k] = (cap_sel == 1) ? fd1    : fd0;
            c_bz[k] = (cap_sel == 1) ? busy1  : busy0;
        end
    endtask

    // Line model: each byte costs 2 idle-level fetch cycles, then
    // start + 8 data (LSB first) + optional even parity + stop bits, CPB cycles each.
    function automatic void build_model(input int n, input int nb, input int par, input int stops);
        int pos;
        int nbits;
        logic lvl;
        for (int k = 0; k < n; k++) begin
            e_tx[k] = 1'b1; e_rd[k] = 1'b0; e_fd[k] = 1'b0; e_bz[k] = 1'b0;
        end
        pos = 0;
        nbits = 1 + 8 + par + stops;
        for (int i = 0; i < nb; i++) begin
            if (pos + 1 < n) begin
                e_rd[pos] = 1'b1;
                e_bz[pos] = 1'b1;
                e_bz[pos + 1] = 1'b1;
            end
            pos += 2;
            for (int b = 0; b < nbits; b++) begin
                if (b == 0)                    lvl = 1'b0;
                else if (b <= 8)               lvl = mbytes[i][b - 1];
                else if (par != 0 && b == 9)   lvl = ^mbytes[i];
                else                           lvl = 1'b1;
                for (int c = 0; c < CPB; c++) begin
                    if (pos < n) begin
                        e_tx[pos] = lvl;
                        e_bz[pos] = 1'b1;
                    end
                    pos++;
                end
            end
            if (pos - 1 < n) e_fd[pos - 1] = 1'b1;
        end
    endfunction

    function automatic int first_diff(input int n);
        for (int k = 0; k < n; k++) begin
            if (c_tx[k] !== e_tx[k] || c_rd[k] !== e_rd[k] ||
                c_fd[k] !== e_fd[k] || c_bz[k] !== e_bz[k]) return k;
        end
        return -1;
    endfunction

    function automatic int count_ones_rd(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) if (c_rd[k] === 1'b1) s++;
        return s;
    endfunction

    function automatic int count_ones_fd(input int n);
        int s = 0;
        for (int k = 0; k < n; k++) if (c_fd[k] === 1'b1) s++;
        return s;
    endfunction

    task automatic test_reset();
        logic [19:0] obs;
        rst = 1'b1;
        #2;
        obs = {tx0, rd_en0, busy0, fd0, cnt0};
        tests++;
        if (obs !== {4'b1000, 16'h0000}) begin
            failed++;
            $display("FAIL reset_state_dut: got %h want %h", obs, {4'b1000, 16'h0000});
        end
        obs = {tx1, rd_en1, busy1, fd1, cnt1};
        tests++;
        if (obs !== {4'b1000, 16'h0000}) begin
            failed++;
            $display("FAIL reset_state_dut_p: got %h want %h", obs, {4'b1000, 16'h0000});
        end
        repeat (2) @(negedge clk_r);
        rst = 1'b0;
    endtask

    task automatic test_single();
        int d;
        int pat [0:9] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        int bad;
        cap_sel = 0;
        tx_en0 = 1'b1;
        push(8'hA5);
        mbytes[0] = 8'hA5;
        capture(60);
        build_model(60, 1, 0, 1);
        exp_cnt0 += 1;
        d = first_diff(60);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL single_a5_wave: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
        end
        bad = -1;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < CPB; c++) begin
                if (bad < 0 && c_tx[2 + CPB*b + c] !== pat[b][0]) bad = b;
            end
        end
        tests++;
        if (bad >= 0) begin
            failed++;
            $display("FAIL single_a5_bits: bit %0d got %b want %0d", bad, c_tx[2 + CPB*bad], pat[bad]);
        end
        tests++;
        if (count_ones_rd(60) != 1) begin
            failed++;
            $display("FAIL single_rd_pulses: got %0d want 1", count_ones_rd(60));
        end
        tests++;
        if (count_ones_fd(60) != 1) begin
            failed++;
            $display("FAIL single_frame_done: got %0d want 1", count_ones_fd(60));
        end
        tests++;
        if (cnt0 !== 16'(exp_cnt0)) begin
            failed++;
            $display("FAIL single_tx_count: got %0d want %0d", cnt0, exp_cnt0);
        end
    endtask

    task automatic test_reset_async();
        logic [19:0] obs;
        push(8'($urandom_range(0, 255)));
        repeat (10) @(negedge clk_r);
        tests++;
        if (busy0 !== 1'b1) begin
            failed++;
            $display("FAIL async_pre_busy: got %b want 1", busy0);
        end
        #1 rst = 1'b1;
        #1;
        obs = {tx0, rd_en0, busy0, fd0, cnt0};
        tests++;
        if (obs !== {4'b1000, 16'h0000}) begin
            failed++;
            $display("FAIL async_reset: got %h want %h", obs, {4'b1000, 16'h0000});
        end
        @(negedge clk_r);
        rst = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
    endtask

    task automatic test_burst();
        int d;
        int g;
        int gaps_bad;
        cap_sel = 0;
        mbytes[0] = 8'h11; mbytes[1] = 8'h22; mbytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) push(mbytes[i]);
        capture(140);
        build_model(140, 3, 0, 1);
        exp_cnt0 += 3;
        d = first_diff(140);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL burst_wave: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
        end
        gaps_bad = -1;
        for (int k = 0, nf = 0; k < 140; k++) begin
            if (c_fd[k] === 1'b1) begin
                nf++;
                if (nf < 3) begin
                    g = 0;
                    for (int j = k + 1; j < 140 && c_tx[j] === 1'b1; j++) g++;
                    if (g != 2 && gaps_bad < 0) gaps_bad = g;
                end
            end
        end
        tests++;
        if (gaps_bad >= 0) begin
            failed++;
            $display("FAIL burst_gap: got %0d idle cycles want 2", gaps_bad);
        end
        tests++;
        if (count_ones_rd(140) != 3) begin
            failed++;
            $display("FAIL burst_rd_pulses: got %0d want 3", count_ones_rd(140));
        end
        tests++;
        if (cnt0 !== 16'(exp_cnt0) || busy0 !== 1'b0) begin
            failed++;
            $display("FAIL burst_end: got count=%0d busy=%b want count=%0d busy=0", cnt0, busy0, exp_cnt0);
        end
    endtask

    task automatic test_empty();
        int d;
        cap_sel = 0;
        tx_en0 = 1'b1;
        capture(200);
        build_model(200, 0, 0, 1);
        d = first_diff(200);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL empty_idle: cycle %0d got tx/rd/fd/busy=%b%b%b%b want 1000",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d]);
        end
        tests++;
        if (underflow != 0) begin
            failed++;
            $display("FAIL empty_underflow: got %0d pops on empty want 0", underflow);
        end
    endtask

    task automatic test_parity_stop2();
        int d;
        int len;
        tx_en0 = 1'b0;
        tx_en1 = 1'b1;
        cap_sel = 1;
        mbytes[0] = 8'h07;
        push(8'h07);
        capture(60);
        build_model(60, 1, 1, 2);
        exp_cnt1 += 1;
        d = first_diff(60);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL parity_wave: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
        end
        tests++;
        if (c_tx[2 + CPB*9 + 1] !== 1'b1) begin
            failed++;
            $display("FAIL parity_bit_07: got %b want 1", c_tx[2 + CPB*9 + 1]);
        end
        len = 0;
        for (int k = 2 + CPB*10; k < 60; k++) begin
            if (c_tx[k] !== 1'b1) break;
            len++;
            if (c_fd[k] === 1'b1) break;
        end
        tests++;
        if (len != 2*CPB) begin
            failed++;
            $display("FAIL stop2_length: got %0d cycles want %0d", len, 2*CPB);
        end
        for (int i = 0; i < 3; i++) begin
            mbytes[i] = 8'($urandom_range(0, 255));
            push(mbytes[i]);
        end
        capture(160);
        build_model(160, 3, 1, 2);
        exp_cnt1 += 3;
        d = first_diff(160);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL parity_random_wave: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
        end
        tests++;
        if (cnt1 !== 16'(exp_cnt1)) begin
            failed++;
            $display("FAIL parity_tx_count: got %0d want %0d", cnt1, exp_cnt1);
        end
        tx_en1 = 1'b0;
        cap_sel = 0;
        tx_en0 = 1'b1;
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] b;
        int d;
        cap_sel = 0;
        tx_en0 = 1'b1;
        b = 8'($urandom_range(0, 255));
        push(b);
        repeat (2 + CPB*4 + 1) @(negedge clk_r);
        tests++;
        if (tx0 !== b[3]) begin
            failed++;
            $display("FAIL mid_data_bit3: got %b want %b", tx0, b[3]);
        end
        #1 rst = 1'b1;
        #1;
        tests++;
        if ({tx0, busy0, rd_en0, fd0} !== 4'b1000) begin
            failed++;
            $display("FAIL mid_data_reset: got tx/busy/rd/fd=%b%b%b%b want 1000", tx0, busy0, rd_en0, fd0);
        end
        @(negedge clk_r);
        rst = 1'b0;
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        mbytes[0] = 8'($urandom_range(0, 255));
        push(mbytes[0]);
        capture(60);
        build_model(60, 1, 0, 1);
        exp_cnt0 += 1;
        d = first_diff(60);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL after_reset_wave: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
        end
        tests++;
        if (cnt0 !== 16'(exp_cnt0)) begin
            failed++;
            $display("FAIL after_reset_count: got %0d want %0d", cnt0, exp_cnt0);
        end
    endtask

    task automatic test_tx_en_drop();
        int d;
        cap_sel = 0;
        tx_en0 = 1'b1;
        mbytes[0] = 8'($urandom_range(0, 255));
        mbytes[1] = 8'($urandom_range(0, 255));
        push(mbytes[0]);
        push(mbytes[1]);
        fork
            capture(60);
            begin
                repeat (3) @(negedge clk_r);
                tx_en0 = 1'b0;
            end
        join
        build_model(60, 1, 0, 1);
        exp_cnt0 += 1;
        d = first_diff(60);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL en_drop_wave: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
        end
        tests++;
        if (int'(wr_ptr - rd_ptr) != 1) begin
            failed++;
            $display("FAIL en_drop_left: got %0d bytes in FIFO want 1", int'(wr_ptr - rd_ptr));
        end
        tx_en0 = 1'b1;
        mbytes[0] = mbytes[1];
        capture(60);
        build_model(60, 1, 0, 1);
        exp_cnt0 += 1;
        d = first_diff(60);
        tests++;
        if (d >= 0) begin
            failed++;
            $display("FAIL en_resume_wave: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                     d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
        end
    endtask

    task automatic test_random();
        int d;
        int nb;
        int n;
        cap_sel = 0;
        tx_en0 = 1'b1;
        for (int r = 0; r < 4; r++) begin
            nb = int'($urandom_range(1, 4));
            for (int i = 0; i < nb; i++) begin
                mbytes[i] = 8'($urandom_range(0, 255));
                push(mbytes[i]);
            end
            n = nb * (2 + 10*CPB) + 10;
            capture(n);
            build_model(n, nb, 0, 1);
            exp_cnt0 += nb;
            d = first_diff(n);
            tests++;
            if (d >= 0) begin
                failed++;
                $display("FAIL random_wave[%0d]: cycle %0d got tx/rd/fd/busy=%b%b%b%b want %b%b%b%b",
                         r, d, c_tx[d], c_rd[d], c_fd[d], c_bz[d], e_tx[d], e_rd[d], e_fd[d], e_bz[d]);
            end
            tests++;
            if (cnt0 !== 16'(exp_cnt0)) begin
                failed++;
                $display("FAIL random_count[%0d]: got %0d want %0d", r, cnt0, exp_cnt0);
            end
        end
        tests++;
        if (underflow != 0) begin
            failed++;
            $display("FAIL final_underflow: got %0d want 0", underflow);
        end
    endtask

    initial begin
        rst = 1'b1;
        tx_en0 = 1'b0;
        tx_en1 = 1'b0;
        test_reset();
        test_single();
        test_reset_async();
        test_burst();
        test_empty();
        test_parity_stop2();
        test_reset_mid_data();
        test_tx_en_drop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
